// File: rtl/cpu_pkg.sv
// Shared definitions for the data-memory arbiter and its users.
//   AW/DW     : default word-address and data widths
//   arb_state_e: arbiter FSM encoding (ARB=0, LOCK1=1)
//   M0/M1     : master index constants
//   dmem_req_t: one master's request payload (we, addr, wdata)
package cpu_pkg;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;

  typedef enum logic {
    ARB   = 1'b0,
    LOCK1 = 1'b1
  } arb_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two memory masters, the arbiter and the data memory.
//   m0_* : CPU load/store port      m1_* : secondary (debug/DMA) port
//   mem_*: single-port data memory (combinational read, synchronous write)
// Modports: slave = arbiter side, master = environment (masters + memory).
interface dmem_arbiter_if
  import cpu_pkg::*;
#(
  parameter int unsigned AW = cpu_pkg::AW,
  parameter int unsigned DW = cpu_pkg::DW
);

  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_lock;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;

  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_wen, mem_addr, mem_din,
    input  mem_dout
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_wen, mem_addr, mem_din,
    output mem_dout
  );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin picker, purely combinational.
//   req   : request vector, bit i = master i
//   last  : index of the most recently granted master
//   gnt_c : one-hot grant (or zero when nobody requests)
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt_c
);

  // On contention the master that was not served last wins.
  always_comb begin
    gnt_c    = 2'b00;
    gnt_c[0] = req[0] & (~req[1] | last);
    gnt_c[1] = req[1] & (~req[0] | ~last);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU (m0) and a
// secondary master (m1). Grants are combinational (same-cycle), read data
// returns registered one cycle after the grant.
//   clk, rst : clock, synchronous active-high reset
//   bus      : dmem_arbiter_if.slave (both master ports + memory port)
// Optional feature macro DMEM_ARB_LOCK_EN: enables the m1 locked-burst state
// (LOCK1) with a burst counter bounded by HOLD_MAX. Without it m1_lock is
// ignored and arbitration is plain round-robin.
module dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 4
) (
  input logic          clk,
  input logic          rst,
  dmem_arbiter_if.slave bus
);

  arb_state_e    state_q, state_d;
  logic          last_q, last_d;
  logic [1:0]    req;
  logic [1:0]    rr_gnt;
  logic [1:0]    gnt;
  logic          rr_last;
  logic          lock_hold;
  dmem_req_t     m0_pl, m1_pl, sel_pl;

  logic          m0_rvalid_q, m0_rvalid_d;
  logic          m1_rvalid_q, m1_rvalid_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;

`ifdef DMEM_ARB_LOCK_EN
  localparam int unsigned CW = $clog2(HOLD_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  logic lock_unused;
  assign lock_unused = bus.m1_lock;
`endif

  assign req   = {bus.m1_req, bus.m0_req};
  assign m0_pl = '{we: bus.m0_we, addr: bus.m0_addr, wdata: bus.m0_wdata};
  assign m1_pl = '{we: bus.m1_we, addr: bus.m1_addr, wdata: bus.m1_wdata};

  // Leaving LOCK1 arbitrates as if m1 was served last, so m0 wins contention.
  assign rr_last = (state_q == LOCK1) ? M1 : last_q;

  rr_pick2 u_pick (
    .req   (req),
    .last  (rr_last),
    .gnt_c (rr_gnt)
  );

  // Next-state, grant and read-return logic.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt         = 2'b00;
    lock_hold   = 1'b0;
    sel_pl      = m0_pl;
`ifdef DMEM_ARB_LOCK_EN
    cnt_d       = cnt_q;
    lock_hold   = (state_q == LOCK1) & bus.m1_req & bus.m1_lock &
                  (cnt_q < CW'(HOLD_MAX));
`endif

    if (rst) begin
      gnt = 2'b00;
    end else if (lock_hold) begin
      gnt = 2'b10;
    end else begin
      gnt = rr_gnt;
    end

    if (gnt[M0]) begin
      last_d = M0;
    end else if (gnt[M1]) begin
      last_d = M1;
    end

`ifdef DMEM_ARB_LOCK_EN
    // Exit from LOCK1 is same-cycle; a fresh locked grant may re-enter at once.
    if (lock_hold) begin
      state_d = LOCK1;
      cnt_d   = cnt_q + CW'(1);
    end else if (gnt[M1] && bus.m1_lock) begin
      state_d = LOCK1;
      cnt_d   = CW'(1);
    end else begin
      state_d = ARB;
      cnt_d   = '0;
    end
`else
    state_d = ARB;
`endif

    if (gnt[M1]) begin
      sel_pl = m1_pl;
    end

    m0_rvalid_d = gnt[M0] & ~bus.m0_we;
    m1_rvalid_d = gnt[M1] & ~bus.m1_we;
    m0_rdata_d  = m0_rvalid_d ? bus.mem_dout : m0_rdata_q;
    m1_rdata_d  = m1_rvalid_d ? bus.mem_dout : m1_rdata_q;
  end

  // State and read-return registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB;
      last_q      <= M1;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
`ifdef DMEM_ARB_LOCK_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
`ifdef DMEM_ARB_LOCK_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.m0_gnt    = gnt[M0];
  assign bus.m1_gnt    = gnt[M1];
  assign bus.mem_wen   = (gnt != 2'b00) & sel_pl.we;
  assign bus.mem_addr  = sel_pl.addr;
  assign bus.mem_din   = sel_pl.wdata;
  assign bus.m0_rvalid = m0_rvalid_q;
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m1_rvalid = m1_rvalid_q;
  assign bus.m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter: a table of per-cycle vectors plus
// hand-written sequences for locked bursts, reset mid-burst and lock drop.
// Expected grants depend on DMEM_ARB_LOCK_EN where the feature matters.
module tb_dmem_arbiter;
  import cpu_pkg::*;

  typedef struct {
    logic        rs;
    logic        r0, w0;
    logic [8:0]  a0;
    logic [31:0] d0;
    logic        r1, w1, lk;
    logic [8:0]  a1;
    logic [31:0] d1;
    logic        g0, g1;
    logic        rv0;
    logic [31:0] rd0;
    logic        rv1;
    logic [31:0] rd1;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] mem [512];

  dmem_arbiter_if bus ();

  dmem_arbiter #(.HOLD_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Data memory model: combinational read, write at the rising edge.
  assign bus.mem_dout = mem[bus.mem_addr];
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
    end else if (bus.mem_wen) begin
      mem[bus.mem_addr] <= bus.mem_din;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, act=running req=finished");
    $fatal(1);
  end

  function automatic vec_t mkv(input logic rs, r0, w0, input logic [8:0] a0,
                               input logic [31:0] d0, input logic r1, w1, lk,
                               input logic [8:0] a1, input logic [31:0] d1,
                               input logic g0, g1, rv0, input logic [31:0] rd0,
                               input logic rv1, input logic [31:0] rd1);
    vec_t v;
    v.rs = rs; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.lk = lk; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.rv0 = rv0; v.rd0 = rd0; v.rv1 = rv1; v.rd1 = rd1;
    return v;
  endfunction

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s act=%h req=%h", nm, fld, act, exp);
    end
  endtask

  // One cycle: drive after the edge, compare at the falling edge.
  task automatic run(input vec_t v, input bit regs, input string nm);
    logic        e_wen;
    logic [8:0]  e_addr;
    logic [31:0] e_din;
    @(posedge clk);
    #1;
    rst = v.rs;
    bus.m0_req = v.r0; bus.m0_we = v.w0; bus.m0_addr = v.a0; bus.m0_wdata = v.d0;
    bus.m1_req = v.r1; bus.m1_we = v.w1; bus.m1_lock = v.lk;
    bus.m1_addr = v.a1; bus.m1_wdata = v.d1;
    e_wen  = v.g1 ? v.w1 : (v.g0 & v.w0);
    e_addr = v.g1 ? v.a1 : v.a0;
    e_din  = v.g1 ? v.d1 : v.d0;
    @(negedge clk);
    chk(nm, "m0_gnt", 32'(bus.m0_gnt), 32'(v.g0));
    chk(nm, "m1_gnt", 32'(bus.m1_gnt), 32'(v.g1));
    chk(nm, "mem_wen", 32'(bus.mem_wen), 32'(e_wen));
    chk(nm, "mem_addr", 32'(bus.mem_addr), 32'(e_addr));
    chk(nm, "mem_din", bus.mem_din, e_din);
    if (regs) begin
      chk(nm, "m0_rvalid", 32'(bus.m0_rvalid), 32'(v.rv0));
      chk(nm, "m0_rdata", bus.m0_rdata, v.rd0);
      chk(nm, "m1_rvalid", 32'(bus.m1_rvalid), 32'(v.rv1));
      chk(nm, "m1_rdata", bus.m1_rdata, v.rd1);
    end
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] W1 = 32'h11111111;
  localparam logic [31:0] W2 = 32'h22222222;

  vec_t tab [13];
  vec_t idle;

  initial begin
    logic [4:0] exp_a, exp_c;

    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_lock = 1'b0;
    bus.m1_addr = '0; bus.m1_wdata = '0;

    idle = mkv(0, 0,0,9'h000,0, 0,0,0,9'h000,0, 0,0, 0,0,0,0);
    // Round-robin after reset: m0 first, then alternating.
    tab[0]  = mkv(0, 1,0,9'h001,0, 1,0,0,9'h002,0, 1,0, 0,0, 0,0);
    tab[1]  = mkv(0, 1,0,9'h001,0, 1,0,0,9'h002,0, 0,1, 1,0, 0,0);
    tab[2]  = mkv(0, 1,0,9'h001,0, 1,0,0,9'h002,0, 1,0, 0,0, 1,0);
    tab[3]  = mkv(0, 1,0,9'h001,0, 1,0,0,9'h002,0, 0,1, 1,0, 0,0);
    // m0 alone: write then read 0x010.
    tab[4]  = mkv(0, 1,1,9'h010,DB, 0,0,0,9'h000,0, 1,0, 0,0, 1,0);
    tab[5]  = mkv(0, 1,0,9'h010,0,  0,0,0,9'h000,0, 1,0, 0,0, 0,0);
    tab[6]  = mkv(0, 0,0,9'h000,0,  0,0,0,9'h000,0, 0,0, 1,DB, 0,0);
    // Both write 0x020 (last=m0 so m1 first), then m1 again.
    tab[7]  = mkv(0, 1,1,9'h020,W1, 1,1,0,9'h020,W2, 0,1, 0,DB, 0,0);
    tab[8]  = mkv(0, 1,1,9'h020,W1, 1,1,0,9'h020,W2, 1,0, 0,DB, 0,0);
    tab[9]  = mkv(0, 0,0,9'h000,0,  1,1,0,9'h020,W2, 0,1, 0,DB, 0,0);
    tab[10] = mkv(0, 0,0,9'h000,0,  1,0,0,9'h020,0,  0,1, 0,DB, 0,0);
    tab[11] = mkv(0, 0,0,9'h000,0,  0,0,0,9'h000,0,  0,0, 0,DB, 1,W2);
    tab[12] = mkv(0, 0,0,9'h000,0,  0,0,0,9'h000,0,  0,0, 0,DB, 0,W2);

    // Reset: no grants or writes even with both requesting writes.
    run(mkv(1, 1,1,9'h005,32'h5, 1,1,1,9'h006,32'h6, 0,0, 0,0,0,0), 1'b1, "rst0");
    clr = 1'b0;
    run(mkv(1, 1,1,9'h005,32'h5, 1,1,1,9'h006,32'h6, 0,0, 0,0,0,0), 1'b1, "rst1");

    for (int i = 0; i < 13; i++) run(tab[i], 1'b1, $sformatf("tab%0d", i));
    chk("mem", "0x020", mem[9'h020], W2);
    chk("mem", "0x010", mem[9'h010], DB);

    // Locked burst with m0 contending; make m0 the last-served master first.
`ifdef DMEM_ARB_LOCK_EN
    exp_a = 5'b01111;
    exp_c = 5'b00011;
`else
    exp_a = 5'b10101;
    exp_c = 5'b00101;
`endif
    run(mkv(0, 1,0,9'h010,0, 0,0,0,9'h000,0, 1,0, 0,0,0,0), 1'b0, "a_pre");
    for (int i = 0; i < 5; i++)
      run(mkv(0, 1,0,9'h010,0, 1,1,1,9'h030,32'hA0 + 32'(i),
              ~exp_a[i], exp_a[i], 0,0,0,0), 1'b0, $sformatf("burst%0d", i));
    run(idle, 1'b0, "a_idle");

    // Reset during a locked m1 write burst (cnt=2).
    run(mkv(0, 1,0,9'h010,0, 0,0,0,9'h000,0, 1,0, 0,0,0,0), 1'b0, "b_pre");
    run(mkv(0, 0,0,9'h000,0, 1,1,1,9'h040,32'hC1, 0,1, 0,0,0,0), 1'b0, "b_lk1");
    run(mkv(0, 0,0,9'h000,0, 1,1,1,9'h040,32'hC2, 0,1, 0,0,0,0), 1'b0, "b_lk2");
    run(mkv(1, 1,0,9'h010,0, 1,1,1,9'h041,32'hBAD0BAD0, 0,0, 0,0,0,0), 1'b0, "b_rst");
    run(mkv(0, 1,0,9'h010,0, 1,1,1,9'h041,32'hBAD0BAD0, 1,0, 0,0,0,0), 1'b1, "b_post");
    chk("mem", "0x041", mem[9'h041], 32'h0);
    chk("mem", "0x040", mem[9'h040], 32'hC2);

    // m1 drops lock after two locked grants while m0 waits.
    for (int i = 0; i < 3; i++)
      run(mkv(0, 1,0,9'h010,0, 1,1,(i < 2) ? 1'b1 : 1'b0,9'h050,32'hE0 + 32'(i),
              ~exp_c[i], exp_c[i], 0,0,0,0), 1'b0, $sformatf("drop%0d", i));
    run(idle, 1'b0, "c_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
